// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the word-copy DMA master:
//   - dma_state_e : FSM state encoding (IDLE, RD_REQ, RD_DATA, WR_REQ)
//   - REG_*       : register offsets on the 2-bit configuration port
//   - CTRL_*      : bit positions inside the CTRL register
//   - is_ctrl_write : decode helper for a CTRL register write strobe
// Optional feature macro used by the files importing this package: DMA_IRQ_EN
// ---------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_REQ  = 2'd3
  } dma_state_e;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // Write side: START, DONE (write-one-to-clear), IRQ_EN, ABORT.
  // Read side:  BUSY, DONE, IRQ_EN.
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_ABORT  = 4;

  function automatic logic is_ctrl_write(input logic we, input logic [1:0] addr);
    return we && (addr == REG_CTRL);
  endfunction

endpackage

// File: rtl/dma_regfile.sv
// ---------------------------------------------------------------------------
// dma_regfile
// Programming registers of the DMA master: SRC, DST, COUNT and CTRL
// (done flag, irq enable), plus the registered completion interrupt.
// SRC/DST/COUNT are write-protected while the engine is busy; the engine
// advances them through step_i after every accepted write beat.
// Optional feature: DMA_IRQ_EN (irq enable bit and interrupt output);
// without it the enable bit reads 0 and the interrupt is tied low.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   cfg_we_i       register write strobe
//   cfg_addr_i     register offset (SRC/DST/COUNT/CTRL)
//   cfg_wdata_i    register write data
//   cfg_rdata_o    combinational readback of cfg_addr_i
//   busy_i         engine is not idle
//   step_i         advance SRC/DST by one word, decrement COUNT
//   set_done_i     transfer finished, set the done flag
//   start_o        CTRL write with start bit set
//   abort_o        CTRL write with abort bit set
//   src_o, dst_o   current source / destination byte addresses
//   count_o        words still to copy
//   irq_o          completion interrupt (level)
// ---------------------------------------------------------------------------
module dma_regfile
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we_i,
  input  logic [1:0]            cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_wdata_i,
  output logic [DATA_WIDTH-1:0] cfg_rdata_o,
  input  logic                  busy_i,
  input  logic                  step_i,
  input  logic                  set_done_i,
  output logic                  start_o,
  output logic                  abort_o,
  output logic [ADDR_WIDTH-1:0] src_o,
  output logic [ADDR_WIDTH-1:0] dst_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  irq_o
);

  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  done_q, done_d;
  logic                  ctrl_wr;
  logic                  irq_en_w;

  assign ctrl_wr = is_ctrl_write(cfg_we_i, cfg_addr_i);
  assign start_o = ctrl_wr && cfg_wdata_i[CTRL_START];
  assign abort_o = ctrl_wr && cfg_wdata_i[CTRL_ABORT];

  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign count_o = count_q;

  // Next-state of the address/count registers. Programming writes and
  // engine steps never collide: writes only land while idle, steps only
  // happen while busy. Address arithmetic wraps silently.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    if (cfg_we_i && !busy_i) begin
      unique case (cfg_addr_i)
        REG_SRC:   src_d   = cfg_wdata_i[ADDR_WIDTH-1:0];
        REG_DST:   dst_d   = cfg_wdata_i[ADDR_WIDTH-1:0];
        REG_COUNT: count_d = cfg_wdata_i[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
    if (step_i) begin
      src_d   = src_q + ADDR_WIDTH'(ADDR_STEP);
      dst_d   = dst_q + ADDR_WIDTH'(ADDR_STEP);
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Done flag: the write-one-to-clear is applied first so that a completion
  // landing in the same cycle keeps the flag set.
  always_comb begin
    done_d = done_q;
    if (ctrl_wr && cfg_wdata_i[CTRL_DONE]) begin
      done_d = 1'b0;
    end
    if (set_done_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef DMA_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;

  // The enable bit is rewritten on every CTRL write, busy or not.
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      irq_en_d = cfg_wdata_i[CTRL_IRQ_EN];
    end
  end

  // The interrupt is registered from the next-state values so it rises
  // on the same edge as the done flag and drops on the clearing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d && irq_en_d;
    end
  end

  assign irq_en_w = irq_en_q;
  assign irq_o    = irq_q;
`else
  assign irq_en_w = 1'b0;
  assign irq_o    = 1'b0;
`endif

  // Readback mux; unused upper bits read as zero.
  always_comb begin
    cfg_rdata_o = '0;
    unique case (cfg_addr_i)
      REG_SRC:   cfg_rdata_o[ADDR_WIDTH-1:0] = src_q;
      REG_DST:   cfg_rdata_o[ADDR_WIDTH-1:0] = dst_q;
      REG_COUNT: cfg_rdata_o[CNT_WIDTH-1:0]  = count_q;
      REG_CTRL: begin
        cfg_rdata_o[CTRL_BUSY]   = busy_i;
        cfg_rdata_o[CTRL_DONE]   = done_q;
        cfg_rdata_o[CTRL_IRQ_EN] = irq_en_w;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_engine.sv
// ---------------------------------------------------------------------------
// dma_engine
// Word-copy DMA bus master placed in front of the bus arbiter. Copies COUNT
// words from SRC to DST as read/write pairs, stalling in place whenever the
// arbiter withholds the grant. Register storage lives in dma_regfile; the
// FSM and the read buffer live here.
// Optional feature: DMA_IRQ_EN (completion interrupt, see dma_regfile).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cfg_we/addr/wdata    register write port (0=SRC 1=DST 2=COUNT 3=CTRL)
//   cfg_rdata            combinational register readback
//   sel_controller_dma   grant from the arbiter
//   bus_data_in          read data returned by the slave
//   dma_io               bus request
//   dma_write            1=write, 0=read
//   dma_address          bus byte address
//   dma_data_out         write data
//   dma_irq              completion interrupt
// ---------------------------------------------------------------------------
module dma_engine
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  sel_controller_dma,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic                  dma_io,
  output logic                  dma_write,
  output logic [ADDR_WIDTH-1:0] dma_address,
  output logic [DATA_WIDTH-1:0] dma_data_out,
  output logic                  dma_irq
);

  dma_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  busy;
  logic                  step;
  logic                  set_done;
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [CNT_WIDTH-1:0]  count;

  assign busy = (state_q != ST_IDLE);

  dma_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .ADDR_STEP  (ADDR_STEP)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .busy_i      (busy),
    .step_i      (step),
    .set_done_i  (set_done),
    .start_o     (start),
    .abort_o     (abort),
    .src_o       (src),
    .dst_o       (dst),
    .count_o     (count),
    .irq_o       (dma_irq)
  );

  // Transfer sequencing. An abort overrides whatever the current state
  // would have done: no step, no done, no buffer capture, straight to idle.
  // A zero-length start completes immediately without touching the bus.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    step     = 1'b0;
    set_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (count == '0) begin
            set_done = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (sel_controller_dma) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        // Losing the grant while data is due means the read must be reissued.
        if (sel_controller_dma) begin
          buffer_d = bus_data_in;
          state_d  = ST_WR_REQ;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (sel_controller_dma) begin
          step = 1'b1;
          if (count == CNT_WIDTH'(1)) begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && busy) begin
      state_d  = ST_IDLE;
      buffer_d = buffer_q;
      step     = 1'b0;
      set_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      buffer_q <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
    end
  end

  // Remembers the last address driven on the bus so it can be held while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_addr_q <= '0;
    end else if (busy) begin
      last_addr_q <= dma_address;
    end
  end

  // Bus outputs decoded from the registered state only.
  always_comb begin
    dma_io      = 1'b0;
    dma_write   = 1'b0;
    dma_address = last_addr_q;
    unique case (state_q)
      ST_RD_REQ, ST_RD_DATA: begin
        dma_io      = 1'b1;
        dma_address = src;
      end
      ST_WR_REQ: begin
        dma_io      = 1'b1;
        dma_write   = 1'b1;
        dma_address = dst;
      end
      default: ;
    endcase
  end

  // The buffer is only reloaded on a granted read, so it already holds the
  // last written word while idle.
  assign dma_data_out = buffer_q;

endmodule
